// File: rtl/fifo_uart_dual.sv
// fifo_uart_dual: 8N1 UART with TX and RX FIFOs, RTS/CTS flow control and
// sticky framing/overrun error flags. Baud timing is derived internally from
// FREQ_HZ/BAUDS (DIV clocks per bit).
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tx / rx             serial out (idle high) / serial in (asynchronous)
//   cts_in              remote ready to receive
//   cts                 we can accept data (RX free entries > CTS_MARGIN)
//   wr, tx_data         push a byte into the TX FIFO
//   tx_full, tx_idle    TX FIFO full / TX FIFO empty and line idle
//   rd, rx_data         pop RX FIFO head / head byte (first-word fall-through)
//   data_ready          RX FIFO non-empty
//   rx_level            RX FIFO occupancy
//   frame_err, overrun  sticky error flags, cleared by err_clr
module fifo_uart_dual #(
    parameter int FREQ_HZ    = 10000000,
    parameter int BAUDS      = 115200,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int CTS_MARGIN = 4,
    parameter int FLOW_CTRL  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        tx,
    input  logic                        rx,
    input  logic                        cts_in,
    output logic                        cts,
    input  logic                        wr,
    input  logic [7:0]                  tx_data,
    input  logic                        rd,
    output logic [7:0]                  rx_data,
    output logic                        data_ready,
    output logic                        tx_full,
    output logic                        tx_idle,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        err_clr
);
    localparam int DIV = FREQ_HZ / BAUDS;
    localparam int CW  = $clog2(DIV);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0]   tx_cnt;
    logic           tx_empty, tx_push, tx_pop, tx_can;

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == (TAW+1)'(TX_DEPTH));
    // A pop in the same cycle frees the slot, so a write to a full FIFO lands.
    assign tx_push  = wr && (!tx_full || tx_pop);
    assign tx_can   = !tx_empty && (cts_in || FLOW_CTRL == 0);

    always_ff @(posedge clk)
        if (tx_push) tx_mem[tx_wp] <= tx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    tx_st_t        tx_st, tx_st_nxt;
    logic [CW-1:0] tx_bcnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_bcnt == BIT_LAST);
    assign tx_idle    = tx_empty && (tx_st == T_IDLE);

    always_comb begin
        tx_st_nxt = tx_st;
        tx_pop    = 1'b0;
        tx        = 1'b1;
        case (tx_st)
            T_IDLE:
                if (tx_can) begin
                    tx_pop    = 1'b1;
                    tx_st_nxt = T_START;
                end
            T_START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_st_nxt = T_DATA;
            end
            T_DATA: begin
                tx = tx_sh[0];
                if (tx_bit_end && tx_bit == 3'd7) tx_st_nxt = T_STOP;
            end
            T_STOP:
                // Chain straight into the next start bit: no idle gap.
                if (tx_bit_end) begin
                    if (tx_can) begin
                        tx_pop    = 1'b1;
                        tx_st_nxt = T_START;
                    end else begin
                        tx_st_nxt = T_IDLE;
                    end
                end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st   <= T_IDLE;
            tx_bcnt <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
        end else begin
            tx_st <= tx_st_nxt;
            if (tx_pop) begin
                tx_sh   <= tx_mem[tx_rp];
                tx_bcnt <= '0;
                tx_bit  <= '0;
            end else if (tx_st != T_IDLE) begin
                tx_bcnt <= tx_bit_end ? '0 : tx_bcnt + 1'b1;
                if (tx_st == T_DATA && tx_bit_end) begin
                    tx_sh  <= {1'b0, tx_sh[7:1]};
                    tx_bit <= tx_bit + 1'b1;
                end
            end
        end
    end

    // ---------------- RX engine ----------------
    rx_st_t        rx_st, rx_st_nxt;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_bcnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_bad;      // stop bit seen low; wait for line to return high
    logic          rx_bit_end, rx_push, rx_full, set_fe, set_ovr;

    assign rx_bit_end = (rx_bcnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_comb begin
        rx_st_nxt = rx_st;
        rx_push   = 1'b0;
        set_fe    = 1'b0;
        set_ovr   = 1'b0;
        case (rx_st)
            R_IDLE:
                if (rx_prev && !rx_s2) rx_st_nxt = R_START;
            R_START:
                // High at mid start bit means the edge was a glitch.
                if (rx_bcnt == HALF_LAST) rx_st_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:
                if (rx_bit_end && rx_bit == 3'd7) rx_st_nxt = R_STOP;
            R_STOP:
                if (rx_bit_end) begin
                    if (rx_s2) begin
                        rx_st_nxt = R_IDLE;
                        if (!rx_bad) begin
                            if (rx_full) set_ovr = 1'b1;
                            else         rx_push = 1'b1;
                        end
                    end else if (!rx_bad) begin
                        set_fe = 1'b1;
                    end
                end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st   <= R_IDLE;
            rx_bcnt <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_bad  <= 1'b0;
        end else begin
            rx_st <= rx_st_nxt;
            case (rx_st)
                R_IDLE: begin
                    rx_bcnt <= '0;
                    rx_bit  <= '0;
                    rx_bad  <= 1'b0;
                end
                R_START:
                    rx_bcnt <= (rx_bcnt == HALF_LAST) ? '0 : rx_bcnt + 1'b1;
                R_DATA:
                    if (rx_bit_end) begin
                        rx_bcnt <= '0;
                        rx_sh   <= {rx_s2, rx_sh[7:1]};
                        rx_bit  <= rx_bit + 1'b1;
                    end else begin
                        rx_bcnt <= rx_bcnt + 1'b1;
                    end
                R_STOP:
                    // Counter parks at mid-bit while waiting for a low stop to end.
                    if (!rx_bit_end)  rx_bcnt <= rx_bcnt + 1'b1;
                    else if (!rx_s2)  rx_bad  <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic           rx_pop;

    assign data_ready = (rx_level != '0);
    assign rx_full    = (rx_level == (RAW+1)'(RX_DEPTH));
    assign rx_pop     = rd && data_ready;
    assign rx_data    = rx_mem[rx_rp];

    always_ff @(posedge clk)
        if (rx_push) rx_mem[rx_wp] <= rx_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp     <= '0;
            rx_rp     <= '0;
            rx_level  <= '0;
            cts       <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: ;
            endcase
            cts <= (RX_DEPTH - int'(rx_level)) > CTS_MARGIN;
            // Set beats clear.
            if (set_fe)       frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (set_ovr)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end
endmodule
